// File: rtl/int2flt_param.sv
// Sequential integer-to-float converter: captures an operand, normalises it one
// bit per clock, then rounds to nearest-even and saturates into the float format.
module int2flt_param #(
  parameter int INT_W = 16,
  parameter int EXP_W = 5,
  parameter int MAN_W = 10,
  parameter int BIAS  = 2**(EXP_W-1)-1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     unsigned_i,
  input  logic [INT_W-1:0]         int_in,
  output logic [EXP_W+MAN_W:0]     flt_out,
  output logic                     ovf,
  output logic                     busy,
  output logic                     done
);
  localparam int FW       = INT_W-1;
  localparam int FX       = FW+MAN_W+2;
  localparam int EXP_INIT = BIAS+INT_W-1;

  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;
  state_t state, state_nxt;

  logic                 sign_q;
  logic [INT_W-1:0]     mag_q;
  logic [EXP_W:0]       exp_q;

  logic                 sign_in;
  logic [INT_W-1:0]     mag_in;
  logic                 norm_end;

  assign sign_in  = int_in[INT_W-1] & ~unsigned_i;
  assign mag_in   = sign_in ? -int_in : int_in;
  assign norm_end = mag_q[INT_W-1] | (mag_q == '0);

  // Fraction below the hidden bit, zero-extended so m, g and s always exist
  logic [FX-1:0]        frac_ext;
  logic [MAN_W-1:0]     m;
  logic                 g, s, round_up;
  logic [MAN_W:0]       m_sum;
  logic [EXP_W+1:0]     exp_r;
  logic [EXP_W+MAN_W:0] flt_nxt;
  logic                 ovf_nxt;

  assign frac_ext = {mag_q[INT_W-2:0], {(MAN_W+2){1'b0}}};
  assign m        = frac_ext[FX-1 -: MAN_W];
  assign g        = frac_ext[FX-1-MAN_W];
  assign s        = |frac_ext[FX-2-MAN_W:0];
  assign round_up = g & (s | m[0]);
  assign m_sum    = {1'b0, m} + {{MAN_W{1'b0}}, round_up};
  assign exp_r    = {1'b0, exp_q} + {{(EXP_W+1){1'b0}}, m_sum[MAN_W]};

  always_comb begin
    flt_nxt = {sign_q, exp_r[EXP_W-1:0], m_sum[MAN_W-1:0]};
    ovf_nxt = 1'b0;
    if (mag_q == '0) begin
      flt_nxt = {sign_q, {(EXP_W+MAN_W){1'b0}}};
    end else if (exp_r > (EXP_W+2)'(2**EXP_W-2)) begin
      // Largest finite value; the all-ones exponent is never emitted
      flt_nxt = {sign_q, EXP_W'(2**EXP_W-2), {MAN_W{1'b1}}};
      ovf_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = NORM;
      NORM:    if (norm_end) state_nxt = ROUND;
      ROUND:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sign_q  <= 1'b0;
      mag_q   <= '0;
      exp_q   <= '0;
      flt_out <= '0;
      ovf     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          sign_q <= sign_in;
          mag_q  <= mag_in;
          exp_q  <= (EXP_W+1)'(EXP_INIT);
        end
        NORM: if (!norm_end) begin
          mag_q <= mag_q << 1;
          exp_q <= exp_q - 1'b1;
        end
        ROUND: begin
          flt_out <= flt_nxt;
          ovf     <= ovf_nxt;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_int2flt_param.sv
// Directed bench for int2flt_param: vector table for values/latency, plus
// handshake, back-to-back and reset-abort sequences; a second instance uses EXP_W=4.
module tb_int2flt_param;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        unsigned_i = 1'b0;
  logic [15:0] int_in = '0;
  logic [15:0] flt_out;
  logic        ovf, busy, done;
  logic [14:0] flt4;
  logic        ovf4, busy4, done4;

  int n_chk = 0;
  int n_fail = 0;
  int done_cnt = 0;

  int2flt_param dut (
    .clk(clk), .reset(reset), .start(start), .unsigned_i(unsigned_i), .int_in(int_in),
    .flt_out(flt_out), .ovf(ovf), .busy(busy), .done(done));

  int2flt_param #(.INT_W(16), .EXP_W(4), .MAN_W(10), .BIAS(7)) dut4 (
    .clk(clk), .reset(reset), .start(start), .unsigned_i(unsigned_i), .int_in(int_in),
    .flt_out(flt4), .ovf(ovf4), .busy(busy4), .done(done4));

  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_cnt++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Returns cycles from the start-sampling edge to the done cycle, or -1 on timeout
  task automatic run_one(input logic uns, input logic [15:0] v, output int lat);
    @(negedge clk);
    unsigned_i = uns; int_in = v; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat = -1;
    for (int c = 1; c <= 60; c++) begin
      if (c > 1) @(negedge clk);
      else @(negedge clk);
      if (done) begin lat = c; break; end
    end
  endtask

  typedef struct {
    logic        uns;
    logic [15:0] in;
    logic [15:0] flt;
    logic        ovf;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int lat, base, first, last, pulses, dbl;
    logic prev;

    vecs[0]  = '{1'b0, 16'h0000, 16'h0000, 1'b0, 2};
    vecs[1]  = '{1'b0, 16'h0001, 16'h3C00, 1'b0, 17};
    vecs[2]  = '{1'b0, 16'h7FFF, 16'h7800, 1'b0, 3};
    vecs[3]  = '{1'b0, 16'h8000, 16'hF800, 1'b0, 2};
    vecs[4]  = '{1'b0, 16'hFFFF, 16'hBC00, 1'b0, 17};
    vecs[5]  = '{1'b0, 16'h0801, 16'h6800, 1'b0, 6};
    vecs[6]  = '{1'b0, 16'h0803, 16'h6802, 1'b0, 6};
    vecs[7]  = '{1'b0, 16'hFFD0, 16'hD200, 1'b0, 12};
    vecs[8]  = '{1'b1, 16'h8000, 16'h7800, 1'b0, 2};
    vecs[9]  = '{1'b1, 16'hFFFF, 16'h7BFF, 1'b1, 2};
    vecs[10] = '{1'b0, 16'h000C, 16'h4A00, 1'b0, 14};
    vecs[11] = '{1'b0, 16'h0003, 16'h4200, 1'b0, 16};

    #1;
    chk("reset flt_out", 32'(flt_out), 0);
    chk("reset ovf", 32'(ovf), 0);
    chk("reset busy", 32'(busy), 0);
    chk("reset done", 32'(done), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    foreach (vecs[i]) begin
      run_one(vecs[i].uns, vecs[i].in, lat);
      chk($sformatf("vec%0d flt", i), 32'(flt_out), 32'(vecs[i].flt));
      chk($sformatf("vec%0d ovf", i), 32'(ovf), 32'(vecs[i].ovf));
      chk($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].lat));
    end

    // Narrow exponent: saturates after the rounding carry; 1 stays exact
    run_one(1'b0, 16'h7FFF, lat);
    chk("exp4 sat flt", 32'(flt4), 32'h3BFF);
    chk("exp4 sat ovf", 32'(ovf4), 1);
    run_one(1'b0, 16'h0001, lat);
    chk("exp4 one flt", 32'(flt4), 32'h1C00);
    chk("exp4 one ovf", 32'(ovf4), 0);

    // start while busy is dropped
    @(negedge clk);
    base = done_cnt;
    unsigned_i = 1'b0; int_in = 16'h0001; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("busy during norm", 32'(busy), 1);
    int_in = 16'h7FFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (25) @(negedge clk);
    chk("ignored start pulses", 32'(done_cnt - base), 1);
    chk("ignored start result", 32'(flt_out), 32'h3C00);
    chk("idle after single", 32'(busy), 0);

    // start held high: back-to-back, single-cycle done pulses every 16 cycles
    int_in = 16'h000C; start = 1'b1;
    first = -1; last = -1; pulses = 0; dbl = 0; prev = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (done) begin
        pulses++;
        if (prev) dbl++;
        if (first < 0) first = c; else last = c;
        chk($sformatf("b2b flt c%0d", c), 32'(flt_out), 32'h4A00);
      end
      prev = done;
    end
    start = 1'b0;
    chk("b2b pulses", 32'(pulses), 2);
    chk("b2b wide done", 32'(dbl), 0);
    chk("b2b period", 32'(last - first), 16);
    repeat (20) @(negedge clk);

    // Reset mid-conversion discards the result
    int_in = 16'h0001; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    base = done_cnt;
    reset = 1'b0;
    #1;
    chk("midreset flt_out", 32'(flt_out), 0);
    chk("midreset ovf", 32'(ovf), 0);
    chk("midreset busy", 32'(busy), 0);
    chk("midreset done", 32'(done), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (25) @(negedge clk);
    chk("midreset no done", 32'(done_cnt - base), 0);
    run_one(1'b0, 16'h0003, lat);
    chk("after reset flt", 32'(flt_out), 32'h4200);
    chk("after reset latency", 32'(lat), 16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
